// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs fields and immediate into a 32-bit word and flags unrepresentable immediates.
// Latency 2 cycles from the accept edge; valid/ready with in_ready = !s1_valid || (!s2_valid || out_ready).
module inst_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       inst_type,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             imm_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] T_U = 3'd0;
  localparam logic [2:0] T_J = 3'd1;
  localparam logic [2:0] T_S = 3'd3;
  localparam logic [2:0] T_B = 3'd4;
  localparam logic [2:0] T_R = 3'd5;

  logic        s1_valid, s2_valid;
  logic        s1_load, s2_load;
  logic [2:0]  s1_type;
  logic [6:0]  s1_opcode, s1_funct7;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_funct3;
  logic [31:0] s1_imm;
  logic        s1_err;
  logic        range_err;
  logic [31:0] word;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Immediate must survive the truncation done by packing; codes 6/7 fall into the I check.
  always_comb begin
    range_err = 1'b0;
    case (inst_type)
      T_U:     range_err = (imm[11:0] != 12'd0);
      T_J:     range_err = imm[0] || ((imm[31:20] != '0) && (imm[31:20] != '1));
      T_B:     range_err = imm[0] || ((imm[31:12] != '0) && (imm[31:12] != '1));
      T_R:     range_err = 1'b0;
      default: range_err = (imm[31:11] != '0) && (imm[31:11] != '1);
    endcase
  end

  always_comb begin
    word = 32'd0;
    case (s1_type)
      T_U:     word = {s1_imm[31:12], s1_rd, s1_opcode};
      T_J:     word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
      T_S:     word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      T_B:     word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:1],
                       s1_imm[11], s1_opcode};
      T_R:     word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      default: word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_type   <= 3'd0;
      s1_opcode <= 7'd0;
      s1_funct7 <= 7'd0;
      s1_rd     <= 5'd0;
      s1_rs1    <= 5'd0;
      s1_rs2    <= 5'd0;
      s1_funct3 <= 3'd0;
      s1_imm    <= 32'd0;
      s1_err    <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_type   <= inst_type;
        s1_opcode <= opcode;
        s1_funct7 <= funct7;
        s1_rd     <= rd;
        s1_rs1    <= rs1;
        s1_rs2    <= rs2;
        s1_funct3 <= funct3;
        s1_imm    <= imm;
        s1_err    <= range_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      inst     <= 32'd0;
      imm_err  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        inst    <= word;
        imm_err <= s1_err;
      end
    end
  end

  // enc_count wraps; err_count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (out_valid && out_ready) begin
      enc_count <= enc_count + CNT_W'(1);
      if (imm_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: scoreboard queue filled on accept, drained on output handshake.
module tb_inst_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    inst_type;
  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   inst;
  logic          imm_err;
  logic [CW-1:0] enc_count, err_count;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t          sb[$];
  exp_t          cur_exp;
  int            vectors = 0;
  int            fails = 0;
  logic [CW-1:0] exp_enc = '0;
  logic [CW-1:0] exp_err = '0;

  localparam logic [6:0] OP_IMM = 7'h13, OP_ST = 7'h23, OP_BR = 7'h63,
                         OP_JAL = 7'h6F, OP_LUI = 7'h37, OP_R = 7'h33;

  inst_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .inst(inst), .imm_err(imm_err),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, then step past the rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("no_stale_word", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("inst", inst, e.inst);
        check("imm_err", {31'd0, imm_err}, {31'd0, e.err});
        exp_enc = exp_enc + 1'b1;
        if (e.err && exp_err != '1) exp_err = exp_err + 1'b1;
      end
    end
    if (acc) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        input logic [31:0] ei, input logic ee);
    inst_type = t; opcode = op; rd = d; rs1 = a; rs2 = b;
    funct3 = f3; funct7 = f7; imm = im;
    cur_exp.inst = ei; cur_exp.err = ee;
  endtask

  task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im,
                       input logic [31:0] ei, input logic ee);
    bit acc;
    acc = 1'b0;
    set_in(t, op, d, a, b, f3, f7, im, ei, ee);
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick(acc);
      if (acc) break;
    end
    if (!acc) check("accept_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int n = 0; n < 40; n++) begin
      if (sb.size() == 0) break;
      tick(acc);
    end
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    sb.delete();
    exp_enc = '0;
    exp_err = '0;
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_word(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  initial begin
    bit acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0);
    #3;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_inst", inst, 32'd0);
    check("reset_imm_err", {31'd0, imm_err}, 32'd0);
    check("reset_enc_count", {28'd0, enc_count}, 32'd0);
    check("reset_err_count", {28'd0, err_count}, 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // addi x1,x2,-1 with latency observation
    set_in(3'd2, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    in_valid = 1'b1;
    tick(acc);
    check("lat_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    check("lat_cycle1_low", {31'd0, out_valid}, 32'd0);
    tick(acc);
    check("lat_cycle2_high", {31'd0, out_valid}, 32'd1);
    drain();

    // back-to-back stream of formats and range boundaries
    drive(3'd2, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, 1'b1);
    drive(3'd3, OP_ST,  5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8,         32'h0051_2423, 1'b0);
    drive(3'd4, OP_BR,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    drive(3'd1, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    drive(3'd4, OP_BR,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0163, 1'b1);
    drive(3'd0, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    drive(3'd0, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
    drive(3'd5, OP_R,   5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'h0020_81B3, 1'b0);
    drive(3'd5, OP_R,   5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0000, 32'h4020_81B3, 1'b0);
    drive(3'd6, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    drive(3'd3, OP_ST,  5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_F800, 32'h8051_2023, 1'b0);
    drive(3'd1, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, 32'h0000_00EF, 1'b1);
    drive(3'd3, OP_ST,  5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'h0000_0800, 32'h8051_2023, 1'b1);
    drain();
    check("stream_enc_count", {28'd0, enc_count}, {28'd0, exp_enc});
    check("stream_err_count", {28'd0, err_count}, {28'd0, exp_err});

    // counter wrap and saturation with a narrow counter
    do_reset();
    for (int k = 0; k < 17; k++)
      drive(3'd2, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, 1'b1);
    drain();
    check("enc_count_wrap", {28'd0, enc_count}, 32'd1);
    check("err_count_sat", {28'd0, err_count}, 32'd15);

    // backpressure: four words, out_ready low for a while
    do_reset();
    out_ready = 1'b0;
    set_in(3'd2, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, addi_word(1), 1'b0);
    in_valid = 1'b1;
    tick(acc);
    check("bp_accept1", {31'd0, acc}, 32'd1);
    set_in(3'd2, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, addi_word(2), 1'b0);
    tick(acc);
    check("bp_accept2", {31'd0, acc}, 32'd1);
    set_in(3'd2, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, addi_word(3), 1'b0);
    tick(acc);
    check("bp_in_ready_fall", {31'd0, acc}, 32'd0);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_inst_a", inst, addi_word(1));
    tick(acc);
    check("bp_stall", {31'd0, acc}, 32'd0);
    check("bp_hold_inst_b", inst, addi_word(1));
    out_ready = 1'b1;
    tick(acc);
    check("bp_accept3", {31'd0, acc}, 32'd1);
    set_in(3'd2, OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, addi_word(4), 1'b0);
    tick(acc);
    check("bp_accept4", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    check("bp_consec_3", {31'd0, out_valid}, 32'd1);
    tick(acc);
    check("bp_consec_4", {31'd0, out_valid}, 32'd1);
    tick(acc);
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    check("bp_queue_empty", sb.size(), 32'd0);
    check("bp_enc_count", {28'd0, enc_count}, 32'd4);

    // reset with words in flight
    out_ready = 1'b0;
    drive(3'd2, OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0393, 1'b1);
    drive(3'd2, OP_IMM, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, addi_word(8), 1'b0);
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) tick(acc);
    check("post_reset_valid", {31'd0, out_valid}, 32'd0);
    check("post_reset_enc", {28'd0, enc_count}, 32'd0);
    check("post_reset_err", {28'd0, err_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
